// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Partial-product selection produced by the recoder.
  typedef enum logic [2:0] {
    BZERO = 3'd0,
    BPOS1 = 3'd1,
    BPOS2 = 3'd2,
    BNEG1 = 3'd3,
    BNEG2 = 3'd4
  } booth_sel_e;

  // Iterations needed to consume a WIDTH-bit operand extended by two bits.
  function automatic int booth_k(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_if.sv
// Request/response bundle between a requester and the Booth multiplier.
interface booth_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: {b[2i+1], b[2i], b[2i-1]} -> multiple of A.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0]  trip,
  output booth_sel_e  sel,
  output logic        neg
);

  // Standard radix-4 table; 000/111 are runs of equal bits and add nothing.
  always_comb begin
    sel = BZERO;
    neg = 1'b0;
    case (trip)
      3'b001, 3'b010: sel = BPOS1;
      3'b011:         sel = BPOS2;
      3'b100: begin
        sel = BNEG2;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        sel = BNEG1;
        neg = 1'b1;
      end
      default: begin
        sel = BZERO;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Iterative radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned per operation. One Booth step per clock, K = WIDTH/2+1 steps.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  booth_if.slave   bus
);

  localparam int K  = booth_k(WIDTH);
  localparam int CW = $clog2(K + 1);
  localparam int XW = WIDTH + 2;   // extended operand width
  localparam int UW = WIDTH + 4;   // upper accumulator field, holds +-2A partial sums
  localparam int LW = 2 * K;       // lower field collecting shifted-out product bits
  localparam int AW = UW + LW;

  state_e               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [XW-1:0]        ax, bx;
  logic [XW:0]          bz;
  logic [AW-1:0]        acc;
  logic signed [AW-1:0] acc_sum, acc_nxt;
  logic [UW-1:0]        mult, addend, upper_sum;
  logic [2*WIDTH-1:0]   prod;
  logic [2:0]           trip;
  booth_sel_e           sel;
  logic                 neg;
  logic                 accept, last;

  assign accept = (state != RUN) && bus.start;
  assign last   = (state == RUN) && (cnt == CW'(K - 1));

  // b[-1] = 0 sits below the extended multiplier; the counter walks the triplets.
  assign bz   = {bx, 1'b0};
  assign trip = bz[2*int'(cnt) +: 3];

  booth_r4_encoder u_enc (
    .trip (trip),
    .sel  (sel),
    .neg  (neg)
  );

  // Add the selected multiple into the upper field, then arithmetic shift by 2.
  always_comb begin
    mult = '0;
    case (sel)
      BPOS1, BNEG1: mult = {{2{ax[XW-1]}}, ax};
      BPOS2, BNEG2: mult = {ax[XW-1], ax, 1'b0};
      default:      mult = '0;
    endcase
    addend    = neg ? (~mult + UW'(1)) : mult;
    upper_sum = acc[AW-1:LW] + addend;
    acc_sum   = {upper_sum, acc[LW-1:0]};
    acc_nxt   = acc_sum >>> 2;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept from IDLE/DONE, count K steps in RUN, one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch extended operands on accept, step the accumulator in RUN,
  // capture the product on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      ax   <= '0;
      bx   <= '0;
      acc  <= '0;
      prod <= '0;
    end else if (accept) begin
      cnt <= '0;
      acc <= '0;
      ax  <= bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
      bx  <= bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      acc <= acc_nxt;
      if (last) prod <= acc_nxt[2*WIDTH-1:0];
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = prod;

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Iterative radix-4 Booth multiplier. It is the successor to the shift-add `multiplier` block and keeps the same start-driven, one-clock usage.
- Adds per-operation signed/unsigned mode, a busy/done handshake, a synchronous reset, and half the iteration count.
- Used by datapath blocks needing a compact, fixed-latency W x W -> 2W multiply.

Parameters:
- WIDTH, default 32: operand width. Must be even and >= 4.
- K (localparam), WIDTH/2+1: number of Booth iterations. It is the same for both modes.

Ports:
- clk  input  1: rising-edge clock.
- rst  input  1: synchronous, active-high reset.
- start  input  1: request. Sampled on an edge where busy=0.
- is_signed  input  1: 1 = operands are two's complement; 0 = operands are unsigned.
- a  input  WIDTH: multiplicand.
- b  input  WIDTH: multiplier.
- busy  output  1: high while an operation is in progress.
- done  output  1: one-cycle pulse when product is valid.
- product  output  2*WIDTH: result. Holds its value until the next accept or reset.

Behaviour:
- Reset: when rst=1 at an edge, state becomes IDLE and busy=0, done=0, product=0, counter=0. rst has priority over start in every state, including mid-RUN; the partial result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1.
- Accept: at an edge with busy=0 and start=1 (state IDLE or DONE):
  - latch a, b and is_signed;
  - clear the accumulator;
  - counter=0; next state RUN.
  - start while busy=1 is ignored. Input changes after accept have no effect.
- Extension: latched operands are extended to WIDTH+2 bits, sign-extended if is_signed=1, zero-extended otherwise.
- RUN step i (i = 0..K-1), one per clock:
  - recode the triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0, to one of {0, +A, +2A, -A, -2A};
  - add the selected value into the upper accumulator field;
  - arithmetic shift right by 2.
  - After step K-1 (counter=K-1), next state is DONE.
- DONE (one cycle): product = low 2*WIDTH bits of the accumulator, registered on entry to DONE; done=1.
  - Next state is IDLE, or RUN if start=1 (back-to-back accept). Back-to-back throughput is one result per K+1 cycles.
- Latency: done is high in the cycle after the (K+1)-th edge following the accept edge.
  - WIDTH=4 gives 4 edges; WIDTH=32 gives 18 edges.
- Arithmetic: the result is the exact product, with no overflow or truncation possible.
  - Signed result range is [-2^(2W-2)+2^(W-1), 2^(2W-2)].
  - -2^(W-1) * -2^(W-1) = +2^(2W-2), positive and representable.
  - Unsigned: (2^W-1)^2 fits in 2W bits.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, RUN, DONE};
  - Booth select enum {BZERO, BPOS1, BPOS2, BNEG1, BNEG2};
  - function for the K computation.
- Sub-module booth_r4_encoder: combinational, 3-bit triplet -> select code plus negate flag. Instantiated once; the triplet is selected by the counter.

Test Plan:
- WIDTH=4, is_signed=0, a=2, b=3, start pulse: done 4 edges after accept, product=8'h06, busy high for 3 cycles.
- WIDTH=4, a=4'hD, b=4'h5:
  - is_signed=1 -> product=8'hF1 (-15);
  - repeat with is_signed=0 -> product=8'h41 (65).
- WIDTH=32, a=b=32'h8000_0000:
  - unsigned -> 64'h4000_0000_0000_0000;
  - signed -> 64'h4000_0000_0000_0000;
  - done 18 edges after accept in both modes.
- WIDTH=32, a=b=32'hFFFF_FFFF:
  - unsigned -> 64'hFFFF_FFFE_0000_0001;
  - signed -> 64'h0000_0000_0000_0001.
- WIDTH=4, start held high, with a/b changed every cycle during RUN:
  - the result reflects only the latched operands;
  - a second accept occurs on the DONE cycle, giving results every 4 cycles;
  - product stays stable between done pulses.
- WIDTH=32, rst asserted 2 cycles into RUN, with start=1 on the same edge: busy=0, done=0, product=0 next cycle. A fresh start (a=7, b=-3 signed) then gives 64'hFFFF_FFFF_FFFF_FFEB.
